mmcm_drp_ctrl: RTL and testbench
================================

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1048576, max SYSCLK cycles to wait for LOCKED.
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 255, max SYSCLK cycles to wait for DRDY per access.
REQ-003 SHALL have port SYSCLK, input, 1, 125 MHz system clock; one clock domain for all logic.
REQ-004 SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port START, input, 1, one-cycle reconfiguration request.
REQ-006 SHALL have port MODE_SEL, input, 2, pixel-clock mode, sampled when START is accepted.
REQ-007 SHALL have DRP master ports DADDR (output, 7), DI (output, 16), DEN (output, 1), DWE (output, 1), DO (input, 16) and DRDY (input, 1), connected to the MMCME2_ADV DRP port.
REQ-008 SHALL have port MMCM_RST, output, 1, MMCM reset, active high.
REQ-009 SHALL have port LOCKED, input, 1, MMCM lock, asynchronous to SYSCLK.
REQ-010 SHALL have status outputs BUSY (1), DONE (1-cycle pulse) and ERR (1, sticky until next accepted START).

Function
REQ-011 SHALL generate the following modes from a 125 MHz input, all with D=5 (VCO=125*M/5):
- 0: M=25, O=25 -> 25 MHz
- 1: M=40, O=25 -> 40 MHz
- 2: M=39, O=15 -> 65 MHz
- 3: M=40, O=20 -> 50 MHz
REQ-012 SHALL hold an internal constant table of 4 modes x 10 entries, each entry {addr[6:0], keepmask[15:0], data[15:0]}.
- Addresses in order: 0x08, 0x09, 0x14, 0x15, 0x16, 0x18, 0x19, 0x1A, 0x4E, 0x4F.
- Values are encoded per the MMCME2 DRP register format for the mode's M/D/O, including lock and filter settings.
REQ-013 SHALL have FSM states IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_OFF, LOCK_WAIT, FIN.
REQ-014 IDLE: START=1 SHALL latch MODE_SEL, clear ERR, set BUSY=1 and go to RST_ON next cycle. START=0 SHALL keep IDLE.
REQ-015 RST_ON SHALL set MMCM_RST=1, clear the entry index to 0 and go to RD; MMCM_RST SHALL stay 1 until RST_OFF.
REQ-016 RD SHALL drive DEN=1, DWE=0 and DADDR=table addr for exactly one cycle, then go to RD_WAIT.
REQ-017 RD_WAIT SHALL capture DO on the DRDY=1 cycle and go to WR.
REQ-018 WR SHALL drive DEN=1, DWE=1, the same DADDR and DI=(DO_captured AND keepmask) OR data for exactly one cycle, then go to WR_WAIT.
REQ-019 WR_WAIT SHALL go to NEXT on DRDY=1.
REQ-020 NEXT SHALL go to RD with index+1 when index<9, else to RST_OFF.
REQ-021 DEN SHALL be 1 only in RD and WR, and SHALL never be 1 while the previous access's DRDY is outstanding.
REQ-022 RST_OFF SHALL set MMCM_RST=0, clear the lock counter and go to LOCK_WAIT.
REQ-023 LOCKED SHALL pass through a 2-flop synchronizer before use; LOCK_WAIT SHALL go to FIN when the synchronized LOCKED=1.
REQ-024 FIN SHALL pulse DONE=1 for one cycle, set BUSY=0 and return to IDLE.
REQ-025 A DRDY timeout (DRDY not seen within DRDY_TIMEOUT cycles in RD_WAIT or WR_WAIT) SHALL set ERR=1, drive MMCM_RST=0 and go to IDLE without a DONE pulse.
REQ-026 A lock timeout (LOCK_WAIT exceeds LOCK_TIMEOUT cycles) SHALL set ERR=1 and go to IDLE without a DONE pulse.
REQ-027 START while BUSY=1 SHALL be ignored; MODE_SEL changes after acceptance SHALL have no effect.
REQ-028 DRDY outside RD_WAIT and WR_WAIT SHALL be ignored.
REQ-029 The timeout counters SHALL be sized for their parameters and SHALL saturate rather than wrap.

Reset
REQ-030 While ARESETN=0, outputs SHALL immediately be DEN=0, DWE=0, DADDR=0, DI=0, MMCM_RST=0, BUSY=0, DONE=0 and ERR=0, with the FSM in IDLE and all counters and index at 0.
REQ-031 Reset mid-sequence SHALL abort with no further DRP access; MMCM_RST=0 lets the MMCM relock to its power-on configuration.
REQ-032 The first START SHALL be accepted no earlier than the second SYSCLK edge after ARESETN rises.

Verification
REQ-033 Mode 1 with a DRP model answering DRDY 3 cycles after DEN -> 10 reads and 10 writes at the addresses of REQ-012 in order, each DI equals the merged value, MMCM_RST=1 throughout, then DONE pulse after LOCKED=1.
REQ-034 DRP model returns DO=0xFFFF with keepmask 0x1000 and data 0x0041 -> DI=0x1041.
REQ-035 START pulsed again during the WR phase of entry 4 with a different MODE_SEL -> ignored; the sequence completes with the original mode's table.
REQ-036 DRDY withheld on entry 2 read -> ERR=1 after 255 cycles, BUSY=0, MMCM_RST=0, no DONE; the next START clears ERR.
REQ-037 LOCKED held 0 with LOCK_TIMEOUT=100 -> ERR=1 after 100 cycles in LOCK_WAIT; LOCKED rising at cycle 50 instead -> DONE within 3 cycles after that.
REQ-038 ARESETN pulsed low during entry 6 -> all outputs return to the REQ-030 values at once, and no DEN follows until a new START.

Source files
------------

// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: reprograms an MMCME2_ADV over DRP to one of four
// pixel-clock modes, then waits for the MMCM to relock.
module mmcm_drp_ctrl #(
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int DRDY_TIMEOUT = 255
) (
    input  logic        SYSCLK,
    input  logic        ARESETN,
    input  logic        START,
    input  logic [1:0]  MODE_SEL,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        MMCM_RST,
    input  logic        LOCKED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int DW = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [LW-1:0] L_LAST = LW'(LOCK_TIMEOUT - 1);
    localparam logic [LW-1:0] L_MAX  = LW'(LOCK_TIMEOUT);
    localparam logic [DW-1:0] D_LAST = DW'(DRDY_TIMEOUT - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(DRDY_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, RST_ON, RD, RD_WAIT, WR,
        WR_WAIT, NEXT, RST_OFF, LOCK_WAIT, FIN
    } state_t;

    function automatic logic [6:0] f_addr(input logic [3:0] i);
        case (i)
            4'd0:    f_addr = 7'h08;
            4'd1:    f_addr = 7'h09;
            4'd2:    f_addr = 7'h14;
            4'd3:    f_addr = 7'h15;
            4'd4:    f_addr = 7'h16;
            4'd5:    f_addr = 7'h18;
            4'd6:    f_addr = 7'h19;
            4'd7:    f_addr = 7'h1A;
            4'd8:    f_addr = 7'h4E;
            default: f_addr = 7'h4F;
        endcase
    endfunction

    function automatic logic [15:0] f_mask(input logic [3:0] i);
        case (i)
            4'd0, 4'd2:       f_mask = 16'h1000;
            4'd4:             f_mask = 16'hC000;
            4'd5:             f_mask = 16'hFC00;
            4'd8:             f_mask = 16'h66FF;
            4'd9:             f_mask = 16'h666F;
            default:          f_mask = 16'h8000;
        endcase
    endfunction

    // M/O dividers, D=5, lock counts and filter bits per mode
    function automatic logic [15:0] f_data(input logic [1:0] m,
                                           input logic [3:0] i);
        case (i)
            4'd0:    f_data = (m == 2'd2) ? 16'h01C8 :
                              (m == 2'd3) ? 16'h028A : 16'h030D;
            4'd1:    f_data = (m == 2'd3) ? 16'h0000 : 16'h0080;
            4'd2:    f_data = (m == 2'd0) ? 16'h030D :
                              (m == 2'd2) ? 16'h04D4 : 16'h0514;
            4'd3:    f_data = (m == 2'd0 || m == 2'd2) ? 16'h0080 : 16'h0000;
            4'd4:    f_data = 16'h2083;
            4'd5:    f_data = (m == 2'd0) ? 16'h0190 : 16'h00FA;
            4'd6:    f_data = 16'h7C01;
            4'd7:    f_data = 16'h7FE9;
            4'd8:    f_data = (m == 2'd0) ? 16'h1900 : 16'h0900;
            default: f_data = (m == 2'd0) ? 16'h8000 : 16'h9000;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_nxt;
    logic [1:0]      r_mode;
    logic [3:0]      r_idx;
    logic [3:0]      w_idx;
    logic [DW-1:0]   r_dcnt;
    logic [LW-1:0]   r_lcnt;
    logic [1:0]      r_rdy;
    logic            r_lk_meta;
    logic            r_lk_sync;
    logic            w_accept;
    logic            w_set_err;
    logic            w_access;
    logic            r_den;
    logic            r_dwe;
    logic [6:0]      r_daddr;
    logic [15:0]     r_di;
    logic            r_mmcm_rst;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    always_comb begin
        w_nxt     = r_state;
        w_idx     = r_idx;
        w_accept  = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (START && r_rdy[1]) begin
                    w_nxt    = RST_ON;
                    w_accept = 1'b1;
                end
            end
            RST_ON: begin
                w_nxt = RD;
                w_idx = 4'd0;
            end
            RD:      w_nxt = RD_WAIT;
            RD_WAIT: begin
                if (DRDY) begin
                    w_nxt = WR;
                end else if (r_dcnt == D_LAST) begin
                    w_nxt     = IDLE;
                    w_set_err = 1'b1;
                end
            end
            WR:      w_nxt = WR_WAIT;
            WR_WAIT: begin
                if (DRDY) begin
                    w_nxt = NEXT;
                end else if (r_dcnt == D_LAST) begin
                    w_nxt     = IDLE;
                    w_set_err = 1'b1;
                end
            end
            NEXT: begin
                if (r_idx < 4'd9) begin
                    w_nxt = RD;
                    w_idx = r_idx + 4'd1;
                end else begin
                    w_nxt = RST_OFF;
                end
            end
            RST_OFF: w_nxt = LOCK_WAIT;
            LOCK_WAIT: begin
                if (r_lk_sync) begin
                    w_nxt = FIN;
                end else if (r_lcnt == L_LAST) begin
                    w_nxt     = IDLE;
                    w_set_err = 1'b1;
                end
            end
            FIN:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        w_access = (w_nxt == RD) || (w_nxt == WR);
    end

    always_ff @(posedge SYSCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= IDLE;
            r_mode     <= '0;
            r_idx      <= '0;
            r_dcnt     <= '0;
            r_lcnt     <= '0;
            r_rdy      <= '0;
            r_lk_meta  <= 1'b0;
            r_lk_sync  <= 1'b0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_daddr    <= '0;
            r_di       <= '0;
            r_mmcm_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_idx     <= w_idx;
            r_rdy     <= {r_rdy[0], 1'b1};
            r_lk_meta <= LOCKED;
            r_lk_sync <= r_lk_meta;
            if (w_accept) r_mode <= MODE_SEL;
            if (r_state == RD || r_state == WR)
                r_dcnt <= '0;
            else if ((r_state == RD_WAIT || r_state == WR_WAIT) && r_dcnt != D_MAX)
                r_dcnt <= r_dcnt + 1'b1;
            if (r_state == RST_OFF)
                r_lcnt <= '0;
            else if (r_state == LOCK_WAIT && r_lcnt != L_MAX)
                r_lcnt <= r_lcnt + 1'b1;
            // outputs follow the next state so they line up with it
            r_den   <= w_access;
            r_dwe   <= (w_nxt == WR);
            r_daddr <= w_access ? f_addr(w_idx) : '0;
            if (w_nxt == WR)
                r_di <= (DO & f_mask(r_idx)) | f_data(r_mode, r_idx);
            else
                r_di <= '0;
            r_mmcm_rst <= w_nxt inside {RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT};
            r_busy     <= !(w_nxt inside {IDLE, FIN});
            r_done     <= (w_nxt == FIN);
            if (w_accept)
                r_err <= 1'b0;
            else if (w_set_err)
                r_err <= 1'b1;
        end
    end

    assign DEN      = r_den;
    assign DWE      = r_dwe;
    assign DADDR    = r_daddr;
    assign DI       = r_di;
    assign MMCM_RST = r_mmcm_rst;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// tb_mmcm_drp_ctrl: random DRP/lock behaviour against a table model
// derived from the M/D/O divider arithmetic.
module tb_mmcm_drp_ctrl;
    logic        SYSCLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  MODE_SEL = 2'd0;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic        DEN;
    logic        DWE;
    logic [15:0] DO = 16'h0;
    logic        DRDY = 1'b0;
    logic        MMCM_RST;
    logic        LOCKED = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    mmcm_drp_ctrl #(.LOCK_TIMEOUT(100), .DRDY_TIMEOUT(255)) dut (
        .SYSCLK(SYSCLK), .ARESETN(ARESETN), .START(START),
        .MODE_SEL(MODE_SEL), .DADDR(DADDR), .DI(DI), .DEN(DEN),
        .DWE(DWE), .DO(DO), .DRDY(DRDY), .MMCM_RST(MMCM_RST),
        .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #4 SYSCLK = ~SYSCLK;

    typedef struct {
        bit          we;
        logic [6:0]  addr;
        logic [15:0] di;
        logic [15:0] dov;
        bit          rst;
    } acc_t;

    acc_t log_q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0, pend = 0, lat_g = 3, lock_dly = 20, lk_cnt = 0;
    int hold_at = -1, den_n = 0, done_n = 0;
    int done_cyc, err_cyc, rstf_cyc, lock_cyc, hold_cyc;
    bit inj_en = 0, inj_on = 0, ones = 0, prev_rst = 0, prev_err = 0;
    logic [1:0]  cur_mode = 2'd0;
    logic [15:0] pend_do = 16'h0;

    int         MV[4] = '{25, 40, 39, 40};
    int         OV[4] = '{25, 25, 15, 20};
    logic [6:0] AD[10] = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h16,
                           7'h18, 7'h19, 7'h1A, 7'h4E, 7'h4F};
    logic [15:0] MK[10] = '{16'h1000, 16'h8000, 16'h1000, 16'h8000,
                            16'hC000, 16'hFC00, 16'h8000, 16'h8000,
                            16'h66FF, 16'h666F};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] lo, input logic [31:0] hi);
        n_chk++;
        if ($isunknown(got) || got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s got %0h want %0h..%0h", tag, got, lo, hi);
        end
    endtask

    function automatic logic [15:0] dreg1(input int n);
        return 16'(((n / 2) << 6) | (n - n / 2));
    endfunction

    function automatic logic [15:0] dreg2(input int n);
        return 16'(((n % 2) << 7) | ((n == 1 ? 1 : 0) << 6));
    endfunction

    function automatic logic [15:0] exp_data(input int mode, input int e);
        int m = MV[mode];
        int o = OV[mode];
        int dv = 5;
        logic [9:0] f;
        f = (m == 25) ? 10'b0111100000 : 10'b0011110000;
        case (e)
            0: return dreg1(o);
            1: return dreg2(o);
            2: return dreg1(m);
            3: return dreg2(m);
            4: return 16'(((dv % 2) << 13) | ((dv / 2) << 6) | (dv - dv / 2));
            5: return (m == 25) ? 16'd400 : 16'd250;
            6: return 16'h7C01;
            7: return 16'h7FE9;
            8: return {f[9], 2'b00, f[8:7], 2'b00, f[6], 8'h00};
            default: return {f[5], 2'b00, f[4:3], 2'b00, f[2:1], 2'b00, f[0], 4'h0};
        endcase
    endfunction

    // DRP slave + MMCM lock model
    initial begin : drp_model
        acc_t a;
        forever begin
            @(posedge SYSCLK);
            #1;
            cyc++;
            DRDY = 1'b0;
            if (!ARESETN) begin
                pend = 0;
                LOCKED = 1'b0;
                lk_cnt = 0;
                prev_rst = 0;
                prev_err = 0;
            end else begin
                if (inj_on) begin
                    START = 1'b0;
                    inj_on = 0;
                end
                if (DONE) begin
                    done_n++;
                    done_cyc = cyc;
                end
                if (ERR && !prev_err) err_cyc = cyc;
                if (!MMCM_RST && prev_rst) rstf_cyc = cyc;
                prev_err = ERR;
                prev_rst = MMCM_RST;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        DRDY = 1'b1;
                        DO = pend_do;
                    end
                end
                if (DEN) begin
                    den_n++;
                    chk("den_outstanding", pend, 0, 0);
                    a.we = DWE;
                    a.addr = DADDR;
                    a.di = DI;
                    a.rst = MMCM_RST;
                    a.dov = ones ? 16'hFFFF : 16'($urandom);
                    if (log_q.size() == hold_at) begin
                        hold_cyc = cyc;
                    end else begin
                        pend = lat_g;
                        pend_do = a.dov;
                    end
                    if (inj_en && DWE && log_q.size() == 9) begin
                        START = 1'b1;
                        MODE_SEL = cur_mode + 2'd1;
                        inj_on = 1;
                    end
                    log_q.push_back(a);
                end
                if (MMCM_RST) begin
                    LOCKED = 1'b0;
                    lk_cnt = 0;
                end else if (lk_cnt < lock_dly) begin
                    lk_cnt++;
                end else if (!LOCKED) begin
                    LOCKED = 1'b1;
                    lock_cyc = cyc;
                end
            end
        end
    end

    task automatic start_pulse(input logic [1:0] mode);
        log_q.delete();
        done_n = 0;
        err_cyc = -100000;
        lock_cyc = -100000;
        hold_cyc = -100000;
        rstf_cyc = -100000;
        cur_mode = mode;
        @(posedge SYSCLK);
        #2;
        START = 1'b1;
        MODE_SEL = mode;
        @(posedge SYSCLK);
        #2;
        START = 1'b0;
        MODE_SEL = 2'($urandom);
        chk("busy_on", BUSY, 1, 1);
        chk("err_clr", ERR, 0, 0);
    endtask

    task automatic check_log(input int mode);
        logic [15:0] ex;
        chk("n_access", log_q.size(), 20, 20);
        for (int i = 0; i < 20 && i < log_q.size(); i++) begin
            chk($sformatf("we%0d", i), log_q[i].we, i % 2, i % 2);
            chk($sformatf("addr%0d", i), log_q[i].addr, AD[i / 2], AD[i / 2]);
            chk($sformatf("rst_hi%0d", i), log_q[i].rst, 1, 1);
            if (i % 2 == 1) begin
                ex = (log_q[i - 1].dov & MK[i / 2]) | exp_data(mode, i / 2);
                chk($sformatf("di%0d", i), log_q[i].di, ex, ex);
            end
        end
    endtask

    // kind 0: completes, 1: DRDY timeout, 2: lock timeout
    task automatic run_seq(input logic [1:0] mode, input int lat,
                           input int lkd, input int hold,
                           input bit inj, input int kind);
        lat_g = lat;
        lock_dly = lkd;
        hold_at = hold;
        inj_en = inj;
        start_pulse(mode);
        for (int k = 0; k < 3000 && BUSY; k++) begin
            @(posedge SYSCLK);
            #2;
        end
        chk("busy_off", BUSY, 0, 0);
        repeat (2) @(posedge SYSCLK);
        #2;
        chk("mmcm_rst_off", MMCM_RST, 0, 0);
        case (kind)
            0: begin
                chk("done_cnt", done_n, 1, 1);
                chk("err_lo", ERR, 0, 0);
                chk("lock_to_done", done_cyc - lock_cyc, 1, 3);
                check_log(mode);
            end
            1: begin
                chk("done_cnt", done_n, 0, 0);
                chk("err_hi", ERR, 1, 1);
                chk("n_access", log_q.size(), 5, 5);
                chk("drdy_tmo", err_cyc - hold_cyc, 255, 258);
            end
            default: begin
                chk("done_cnt", done_n, 0, 0);
                chk("err_hi", ERR, 1, 1);
                chk("lock_tmo", err_cyc - rstf_cyc, 100, 103);
                check_log(mode);
            end
        endcase
        inj_en = 0;
        hold_at = -1;
    endtask

    task automatic run_reset(input logic [1:0] mode);
        lat_g = 2;
        lock_dly = 20;
        start_pulse(mode);
        for (int k = 0; k < 500 && log_q.size() < 13; k++) begin
            @(posedge SYSCLK);
            #2;
        end
        chk("reach_entry6", log_q.size(), 13, 13);
        ARESETN = 1'b0;
        #1;
        chk("abort_out", {DEN, DWE, DADDR, DI, MMCM_RST, BUSY, DONE, ERR}, 0, 0);
        den_n = 0;
        repeat (2) @(posedge SYSCLK);
        #2;
        ARESETN = 1'b1;
        repeat (40) @(posedge SYSCLK);
        #2;
        chk("no_den_after", den_n, 0, 0);
        chk("idle_busy", BUSY, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge SYSCLK);
        #2;
        chk("reset_out", {DEN, DWE, DADDR, DI, MMCM_RST, BUSY, DONE, ERR}, 0, 0);
        ARESETN = 1'b1;
        START = 1'b1;
        MODE_SEL = 2'd1;
        @(posedge SYSCLK);
        #2;
        START = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #2;
        chk("early_start", BUSY, 0, 0);
        chk("early_den", den_n, 0, 0);

        run_seq(2'd1, 3, 20, -1, 0, 0);
        ones = 1;
        run_seq(2'd0, 2, 10, -1, 0, 0);
        chk("di_ones", log_q.size() > 1 ? log_q[1].di : 16'h0, 16'h130D, 16'h130D);
        ones = 0;
        run_seq(2'd2, 4, 15, -1, 1, 0);
        run_seq(2'd3, 3, 15, 4, 0, 1);
        run_seq(2'd0, 2, 15, -1, 0, 0);
        run_seq(2'd1, 1, 1000000, -1, 0, 2);
        run_seq(2'd2, 2, 50, -1, 0, 0);
        run_reset(2'd3);
        for (int r = 0; r < 5; r++) begin
            ones = ($urandom % 2) == 1;
            run_seq(2'($urandom), $urandom_range(1, 6),
                    $urandom_range(2, 60), -1, 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
